// File: rtl/min_search_unit.sv
// min_search_unit
// Scans a stream of NUM_CAND candidate values, tracks the running minimum and
// the index where it was first seen, and drives the write port of the
// processor's minimum-holding register.
//
// Ports:
//   Clk        clock, rising edge
//   Reset      synchronous, active-high
//   Start      one-cycle pulse, begins a search when idle
//   CandValid  candidate present on CandData
//   CandReady  unit accepts a candidate this cycle (high only while scanning)
//   CandData   candidate value
//   MinWrite   write enable to the min register, one cycle per improvement
//   MinData    running minimum (value for the min register)
//   MinIndex   index of the current minimum
//   Busy       search in progress
//   Done       one-cycle pulse when a search completes
//
// Build option: define MIN_SEARCH_SIGNED_EN to compare candidates as
// two's-complement signed values; otherwise the comparison is unsigned.
module min_search_unit #(
  parameter int                DATA_W   = 32,
  parameter int                IDX_W    = 16,
  parameter int                NUM_CAND = 64,
  parameter logic [DATA_W-1:0] INIT_MIN = 32'h00FFFFFF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              CandValid,
  output logic              CandReady,
  input  logic [DATA_W-1:0] CandData,
  output logic              MinWrite,
  output logic [DATA_W-1:0] MinData,
  output logic [IDX_W-1:0]  MinIndex,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

  // Index of the final candidate; NUM_CAND may equal 2**IDX_W, so the
  // subtraction is done before truncation.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q;
  logic               xfer;

  // Strict less-than: ties never update, so the first occurrence wins.
  function automatic logic cand_less(input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b);
`ifdef MIN_SEARCH_SIGNED_EN
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    sa = a;
    sb = b;
    return sa < sb;
`else
    return a < b;
`endif
  endfunction

  assign CandReady = (state_q == SCAN);
  assign xfer      = CandReady & CandValid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = SCAN;
      SCAN:    if (xfer && (cnt_q == LAST_IDX)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      MinData  <= INIT_MIN;
      MinIndex <= '0;
      MinWrite <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      MinWrite <= 1'b0;
      Done     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            MinData  <= INIT_MIN;
            MinIndex <= '0;
            cnt_q    <= '0;
            Busy     <= 1'b1;
          end
        end
        SCAN: begin
          if (xfer) begin
            cnt_q <= cnt_q + 1'b1;
            if (cand_less(CandData, MinData)) begin
              MinData  <= CandData;
              MinIndex <= cnt_q;
              MinWrite <= 1'b1;
            end
          end
        end
        FIN: begin
          // Completion pulse lands the cycle after the last MinWrite.
          Done <= 1'b1;
          Busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_min_search_unit.sv
module tb_min_search_unit;

  localparam int          N    = 4;
  localparam logic [31:0] INIT = 32'h00FFFFFF;

  logic        Clk = 1'b0;
  logic        Reset, Start, CandValid, CandReady, MinWrite, Busy, Done;
  logic [31:0] CandData, MinData;
  logic [15:0] MinIndex;

  min_search_unit #(.DATA_W(32), .IDX_W(16), .NUM_CAND(N), .INIT_MIN(INIT)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .CandValid(CandValid),
    .CandReady(CandReady), .CandData(CandData), .MinWrite(MinWrite),
    .MinData(MinData), .MinIndex(MinIndex), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit m_less(input logic [31:0] a, input logic [31:0] b);
`ifdef MIN_SEARCH_SIGNED_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  // Reference: search phase 0=idle 1=scanning 2=finishing
  int          m_phase = 0, m_cnt = 0, m_idx = 0;
  logic [31:0] m_min = INIT;
  bit          m_busy = 0, m_mw, m_done;
  logic [31:0] cands[$];
  int          mw_seen = 0, done_cnt = 0;

  always begin
    logic r, s, v;
    logic [31:0] d;
    @(posedge Clk);
    r = Reset; s = Start; v = CandValid; d = CandData;
    m_mw = 0; m_done = 0;
    if (r) begin
      m_phase = 0; m_min = INIT; m_idx = 0; m_cnt = 0; m_busy = 0;
    end else begin
      case (m_phase)
        0: if (s) begin
          m_phase = 1; m_min = INIT; m_idx = 0; m_cnt = 0; m_busy = 1;
          cands.delete(); mw_seen = 0; done_cnt = 0;
        end
        1: if (v) begin
          cands.push_back(d);
          if (m_less(d, m_min)) begin m_min = d; m_idx = m_cnt; m_mw = 1; end
          if (m_cnt == N - 1) m_phase = 2;
          m_cnt++;
        end
        default: begin m_done = 1; m_busy = 0; m_phase = 0; end
      endcase
    end
    #1;
    chk("CandReady", CandReady, m_phase == 1);
    chk("MinWrite", MinWrite, m_mw);
    chk("MinData", MinData, m_min);
    chk("MinIndex", MinIndex, m_idx);
    chk("Busy", Busy, m_busy);
    chk("Done", Done, m_done);
    if (MinWrite === 1'b1) mw_seen++;
    if (Done === 1'b1) done_cnt++;
    if (m_done) begin
      // Whole-search view: first occurrence of the smallest value below INIT.
      logic [31:0] best;
      int bi, nimp;
      best = INIT; bi = 0; nimp = 0;
      foreach (cands[i]) if (m_less(cands[i], best)) begin best = cands[i]; bi = i; nimp++; end
      chk("final_count", cands.size(), N);
      chk("final_data", MinData, best);
      chk("final_index", MinIndex, bi);
      chk("final_pulses", mw_seen, nimp);
    end
  end

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic start_search();
    Start = 1'b1; tick(); Start = 1'b0;
  endtask

  // Feed N values, inserting up to stall_max idle cycles before each one;
  // idle cycles carry junk data and stray Start pulses that must be ignored.
  task automatic feed(input logic [31:0] vals[N], input int stall_min, input int stall_max);
    for (int i = 0; i < N; i++) begin
      int st;
      st = $urandom_range(stall_max, stall_min);
      for (int k = 0; k < st; k++) begin
        CandValid = 1'b0; CandData = $urandom; Start = ($urandom_range(3, 0) == 0);
        tick();
      end
      Start = 1'b0; CandValid = 1'b1; CandData = vals[i];
      tick();
    end
    CandValid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 20; k++) begin
      if (done_cnt != 0) break;
      tick();
    end
    chk({name, "_done_pulses"}, done_cnt, 1);
    tick(); tick();
  endtask

  task automatic run(input string name, input logic [31:0] vals[N], input int smin, input int smax);
    done_cnt = 0;
    start_search();
    feed(vals, smin, smax);
    wait_done(name);
  endtask

  logic [31:0] v4[N];

  initial begin
    Reset = 1'b1; Start = 1'b0; CandValid = 1'b0; CandData = '0;
    tick(); tick();
    Reset = 1'b0;
    chk("reset_mindata", MinData, INIT);
    chk("reset_busy", Busy, 0);
    // Junk candidates while idle are ignored.
    CandValid = 1'b1; CandData = 32'd1; tick(); tick(); CandValid = 1'b0; tick();

    v4 = '{32'd50, 32'd20, 32'd30, 32'd10};
    run("descend", v4, 0, 0);
    chk("descend_data", MinData, 10);
    chk("descend_idx", MinIndex, 3);
    chk("descend_pulses", mw_seen, 3);
    chk("descend_busy", Busy, 0);

    v4 = '{32'd7, 32'd7, 32'd9, 32'd7};
    run("tie", v4, 0, 0);
    chk("tie_data", MinData, 7);
    chk("tie_idx", MinIndex, 0);
    chk("tie_pulses", mw_seen, 1);

    v4 = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    run("allmax", v4, 0, 0);
`ifndef MIN_SEARCH_SIGNED_EN
    chk("allmax_data", MinData, INIT);
    chk("allmax_pulses", mw_seen, 0);
`endif

    v4 = '{INIT, INIT, INIT, INIT};
    run("eqinit", v4, 0, 1);
    chk("eqinit_data", MinData, INIT);
    chk("eqinit_idx", MinIndex, 0);
    chk("eqinit_pulses", mw_seen, 0);

    v4 = '{32'd5, 32'd3, 32'd8, 32'd9};
    run("stall", v4, 2, 2);
    chk("stall_data", MinData, 3);
    chk("stall_idx", MinIndex, 1);
    chk("stall_pulses", mw_seen, 2);

    v4 = '{32'hFFFFFFFE, 32'd5, 32'd7, 32'd9};
    run("sign", v4, 0, 0);
`ifdef MIN_SEARCH_SIGNED_EN
    chk("sign_data", MinData, 32'hFFFFFFFE);
    chk("sign_idx", MinIndex, 0);
`else
    chk("sign_data", MinData, 5);
    chk("sign_idx", MinIndex, 1);
`endif

    // Abort after two candidates.
    done_cnt = 0;
    start_search();
    CandValid = 1'b1; CandData = 32'd4; tick();
    CandData = 32'd2; tick();
    CandValid = 1'b0; Reset = 1'b1; tick(); Reset = 1'b0;
    chk("abort_busy", Busy, 0);
    chk("abort_data", MinData, INIT);
    chk("abort_idx", MinIndex, 0);
    for (int k = 0; k < 4; k++) tick();
    chk("abort_no_done", done_cnt, 0);
    v4 = '{32'd40, 32'd41, 32'd12, 32'd13};
    run("after_abort", v4, 0, 0);
    chk("after_abort_data", MinData, 12);
    chk("after_abort_idx", MinIndex, 2);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++)
        v4[i] = ($urandom_range(3, 0) == 0) ? $urandom : $urandom_range(20, 0);
      run("random", v4, 0, 2);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
